// File: rtl/vga_hvsync_gen_pkg.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module : vga_hvsync_gen_pkg
// Desc   : Shared video timing constants and counter widths for the Pong path.
// Rev    : 1.0 - initial release
//==============================================================================
package vga_hvsync_gen_pkg;

  localparam int c_H_ACTIVE     = 640;
  localparam int c_H_TOTAL      = 768;
  localparam int c_H_SYNC_START = 720;
  localparam int c_H_SYNC_LEN   = 16;

  localparam int c_V_ACTIVE     = 480;
  localparam int c_V_TOTAL      = 512;
  localparam int c_V_SYNC_START = 500;
  localparam int c_V_SYNC_LEN   = 1;

  localparam int c_CX_W = 10;
  localparam int c_CY_W = 9;

endpackage

`default_nettype wire

// File: rtl/vga_hvsync_gen_timing_counter.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module : vga_timing_counter
// Desc   : One raster axis: wrapping counter with registered sync/active flags.
// Rev    : 1.0 - initial release
//==============================================================================
module vga_timing_counter #(
  parameter int W          = 10,
  parameter int TOTAL      = 768,
  parameter int SYNC_START = 720,
  parameter int SYNC_LEN   = 16,
  parameter int ACTIVE     = 640
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         sync_n,
  output logic         active
);

  localparam logic [W-1:0] c_LAST    = W'(TOTAL - 1);
  localparam logic [W:0]   c_SYNC_LO = (W+1)'(SYNC_START);
  localparam logic [W:0]   c_SYNC_HI = (W+1)'(SYNC_START + SYNC_LEN);
  localparam logic [W:0]   c_ACT     = (W+1)'(ACTIVE);

  logic [W-1:0] w_countNext;
  logic [W:0]   w_countExt;

  assign wrap = inc && (count == c_LAST);

  always_comb begin
    w_countNext = count;
    if (inc) begin
      w_countNext = (count == c_LAST) ? '0 : count + 1'b1;
    end
  end

  // Flags are decoded from the next count so they line up with count itself.
  assign w_countExt = {1'b0, w_countNext};

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      sync_n <= 1'b1;
      active <= 1'b0;
    end else begin
      count  <= w_countNext;
      sync_n <= !((w_countExt >= c_SYNC_LO) && (w_countExt < c_SYNC_HI));
      active <= (w_countExt < c_ACT);
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_hvsync_gen.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module : vga_hvsync_gen
// Desc   : VGA raster timing: pixel/line counters, active-low syncs, display qualifier.
// Rev    : 1.0 - initial release
//==============================================================================
module vga_hvsync_gen
  import vga_hvsync_gen_pkg::*;
#(
  parameter int H_ACTIVE     = c_H_ACTIVE,
  parameter int H_TOTAL      = c_H_TOTAL,
  parameter int H_SYNC_START = c_H_SYNC_START,
  parameter int H_SYNC_LEN   = c_H_SYNC_LEN,
  parameter int V_ACTIVE     = c_V_ACTIVE,
  parameter int V_TOTAL      = c_V_TOTAL,
  parameter int V_SYNC_START = c_V_SYNC_START,
  parameter int V_SYNC_LEN   = c_V_SYNC_LEN
) (
  input  logic              clk,
  input  logic              reset,
  output logic              vga_h_sync,
  output logic              vga_v_sync,
  output logic              inDisplayArea,
  output logic [c_CX_W-1:0] CounterX,
  output logic [c_CY_W-1:0] CounterY
);

  logic w_hWrap;
  logic w_hActive;
  logic w_vActive;
  logic w_vWrapUnused;

  vga_timing_counter #(
    .W          (c_CX_W),
    .TOTAL      (H_TOTAL),
    .SYNC_START (H_SYNC_START),
    .SYNC_LEN   (H_SYNC_LEN),
    .ACTIVE     (H_ACTIVE)
  ) u_hCounter (
    .clk    (clk),
    .reset  (reset),
    .inc    (1'b1),
    .count  (CounterX),
    .wrap   (w_hWrap),
    .sync_n (vga_h_sync),
    .active (w_hActive)
  );

  // Lines advance only on the pixel edge where the horizontal counter wraps.
  vga_timing_counter #(
    .W          (c_CY_W),
    .TOTAL      (V_TOTAL),
    .SYNC_START (V_SYNC_START),
    .SYNC_LEN   (V_SYNC_LEN),
    .ACTIVE     (V_ACTIVE)
  ) u_vCounter (
    .clk    (clk),
    .reset  (reset),
    .inc    (w_hWrap),
    .count  (CounterY),
    .wrap   (w_vWrapUnused),
    .sync_n (vga_v_sync),
    .active (w_vActive)
  );

  assign inDisplayArea = w_hActive && w_vActive;

endmodule

`default_nettype wire

// File: tb/tb_vga_hvsync_gen.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module : tb_vga_hvsync_gen
// Desc   : Scoreboard bench: full-size instance for line timing, shrunk instance for frames.
// Rev    : 1.0 - initial release
//==============================================================================
module tb_vga_hvsync_gen;

  // Shrunk vertical/horizontal geometry so whole frames fit in a short run.
  localparam int B_HT = 96, B_HA = 80, B_HSS = 88, B_HSL = 4;
  localparam int B_VT = 40, B_VA = 30, B_VSS = 33, B_VSL = 2;

  typedef struct packed {
    logic       rst;
    logic [9:0] x;
    logic [8:0] y;
    logic       hs;
    logic       vs;
    logic       de;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstA = 1'b1, rstB = 1'b1;
  logic       hsA, vsA, deA, hsB, vsB, deB;
  logic [9:0] xA, xB;
  logic [8:0] yA, yB;

  exp_t qA[$], qB[$];
  exp_t curA = '0, curB = '0;
  int   vectors = 0, errors = 0;

  always #5 clk = ~clk;

  vga_hvsync_gen u_dutA (
    .clk(clk), .reset(rstA), .vga_h_sync(hsA), .vga_v_sync(vsA),
    .inDisplayArea(deA), .CounterX(xA), .CounterY(yA)
  );

  vga_hvsync_gen #(
    .H_ACTIVE(B_HA), .H_TOTAL(B_HT), .H_SYNC_START(B_HSS), .H_SYNC_LEN(B_HSL),
    .V_ACTIVE(B_VA), .V_TOTAL(B_VT), .V_SYNC_START(B_VSS), .V_SYNC_LEN(B_VSL)
  ) u_dutB (
    .clk(clk), .reset(rstB), .vga_h_sync(hsB), .vga_v_sync(vsB),
    .inDisplayArea(deB), .CounterX(xB), .CounterY(yB)
  );

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t nextExp(input exp_t c, input logic r,
                                   input int ht, ha, hss, hsl, vt, va, vss, vsl);
    exp_t n;
    int   x, y;
    if (r) begin
      x = 0; y = 0;
    end else begin
      x = int'(c.x); y = int'(c.y);
      if (x == ht - 1) begin
        x = 0;
        y = (y == vt - 1) ? 0 : y + 1;
      end else begin
        x = x + 1;
      end
    end
    n.rst = r;
    n.x   = 10'(x);
    n.y   = 9'(y);
    n.hs  = r ? 1'b1 : !(x >= hss && x < hss + hsl);
    n.vs  = r ? 1'b1 : !(y >= vss && y < vss + vsl);
    n.de  = r ? 1'b0 : (x < ha && y < va);
    return n;
  endfunction

  // Stimulus: set resets, clock once, push the expected post-edge state.
  task automatic step(input logic ra, input logic rb);
    @(negedge clk);
    rstA = ra;
    rstB = rb;
    @(posedge clk);
    curA = nextExp(curA, ra, 768, 640, 720, 16, 512, 480, 500, 1);
    curB = nextExp(curB, rb, B_HT, B_HA, B_HSS, B_HSL, B_VT, B_VA, B_VSS, B_VSL);
    qA.push_back(curA);
    qB.push_back(curB);
  endtask

  // Monitor: per-clock scoreboard compare plus sync width/period trackers.
  int   cyc = 0;
  int   aPrevHs = 1, aLow = 0, aLastFall = -1, aDeCnt = 0;
  int   bPrevVs = 1, bLow = 0, bLastFall = -1, bPeriods = 0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (qA.size() > 0) begin
      e = qA.pop_front();
      check("A.X", int'(xA), int'(e.x));
      check("A.Y", int'(yA), int'(e.y));
      check("A.hs", int'(hsA), int'(e.hs));
      check("A.vs", int'(vsA), int'(e.vs));
      check("A.de", int'(deA), int'(e.de));
      if (e.rst) begin
        aPrevHs = 1; aLow = 0; aLastFall = -1; aDeCnt = 0;
      end else begin
        if (aPrevHs == 1 && hsA == 1'b0) begin
          if (aLastFall >= 0) begin
            check("A.hs_period", cyc - aLastFall, 768);
            check("A.de_per_line", aDeCnt, 640);
          end
          aLastFall = cyc;
          aDeCnt = 0;
        end
        if (aPrevHs == 0 && hsA == 1'b1) begin
          check("A.hs_width", aLow, 16);
          aLow = 0;
        end
        if (hsA == 1'b0) aLow++;
        if (deA) aDeCnt++;
        aPrevHs = int'(hsA);
      end
    end
    if (qB.size() > 0) begin
      e = qB.pop_front();
      check("B.X", int'(xB), int'(e.x));
      check("B.Y", int'(yB), int'(e.y));
      check("B.hs", int'(hsB), int'(e.hs));
      check("B.vs", int'(vsB), int'(e.vs));
      check("B.de", int'(deB), int'(e.de));
      if (e.rst) begin
        bPrevVs = 1; bLow = 0; bLastFall = -1;
      end else begin
        if (bPrevVs == 1 && vsB == 1'b0) begin
          if (bLastFall >= 0) begin
            check("B.vs_period", cyc - bLastFall, 3840);
            bPeriods++;
          end
          bLastFall = cyc;
        end
        if (bPrevVs == 0 && vsB == 1'b1) begin
          check("B.vs_width", bLow, 192);
          bLow = 0;
        end
        if (vsB == 1'b0) bLow++;
        bPrevVs = int'(vsB);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    repeat (3) step(1'b1, 1'b1);
    #1;
    check("rst.X", int'(xA), 0);
    check("rst.Y", int'(yA), 0);
    check("rst.hs", int'(hsA), 1);
    check("rst.vs", int'(vsA), 1);
    check("rst.de", int'(deA), 0);

    step(1'b0, 1'b0);
    #1;
    check("rel.X", int'(xA), 1);
    check("rel.Y", int'(yA), 0);
    check("rel.de", int'(deA), 1);

    // Covers several 768-clock lines on A and two vsync falls on B.
    repeat (7500) step(1'b0, 1'b0);

    n = 0;
    while (curA.x != 10'd300 && n < 1000) begin
      step(1'b0, 1'b0);
      n++;
    end
    check("A.reach_x300", int'(curA.x), 300);
    step(1'b1, 1'b0);
    #1;
    check("midrst.X", int'(xA), 0);
    check("midrst.Y", int'(yA), 0);
    check("midrst.de", int'(deA), 0);
    check("midrst.hs", int'(hsA), 1);
    check("midrst.vs", int'(vsA), 1);
    step(1'b0, 1'b0);
    #1;
    check("midrst.X1", int'(xA), 1);

    n = 0;
    while (!(curB.x == 10'd50 && curB.y == 9'd20) && n < 4000) begin
      step(1'b0, 1'b0);
      n++;
    end
    check("B.reach_50_20", int'(curB.x) * 1000 + int'(curB.y), 50020);
    step(1'b0, 1'b1);
    repeat (8000) step(1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("B.vs_periods_seen", int'(bPeriods >= 2), 1);
    check("queues_drained", qA.size() + qB.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
